// File: rtl/vga_pkg.sv
// Shared raster-timing package for the drawing pipeline: default 1024x768@60
// timing constants, counter/colour widths and small decode helpers.
package vga_pkg;

  // Counter and pixel widths shared by every drawing stage
  localparam int unsigned VGA_CNT_W       = 11;
  localparam int unsigned RGB_W           = 12;
  localparam int unsigned VGA_FRAME_CNT_W = 16;

  // Horizontal timing, 1024x768@60 with a 65 MHz pixel clock
  localparam int unsigned VGA_H_ACTIVE = 1024;
  localparam int unsigned VGA_H_FP     = 24;
  localparam int unsigned VGA_H_SYNC   = 136;
  localparam int unsigned VGA_H_BP     = 160;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing
  localparam int unsigned VGA_V_ACTIVE = 768;
  localparam int unsigned VGA_V_FP     = 3;
  localparam int unsigned VGA_V_SYNC   = 6;
  localparam int unsigned VGA_V_BP     = 29;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync/blank flags travelling alongside hcount/vcount
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_flags_t;

  // Inclusive window test on a raster coordinate
  function automatic logic in_window(input logic [VGA_CNT_W-1:0] val,
                                     input logic [VGA_CNT_W-1:0] lo,
                                     input logic [VGA_CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis. Counts 0..TOTAL-1 while enabled and
// exposes its next value so the parent can register decodes coherently.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W = VGA_CNT_W,
  parameter int unsigned TOTAL = VGA_H_TOTAL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_c,
  output logic             wrap_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: hold when disabled, wrap to zero after the last position
  always_comb begin
    count_d = count_q;
    wrap_c  = 1'b0;
    if (en_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap_c  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_c = count_d;

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator (1024x768@60 by default).
// Optional frame tick / frame counter compiled in with VGA_TIMING_FRAME_CNT_EN;
// without it both ports are tied to zero and carry no flops.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  output logic [VGA_CNT_W-1:0]       hcount,
  output logic [VGA_CNT_W-1:0]       vcount,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       hblnk,
  output logic                       vblnk,
  output logic                       frame_tick,
  output logic [VGA_FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode windows, inclusive bounds
  localparam logic [VGA_CNT_W-1:0] H_BLNK_LO = VGA_CNT_W'(H_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] H_BLNK_HI = VGA_CNT_W'(H_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] H_SYNC_LO = VGA_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [VGA_CNT_W-1:0] H_SYNC_HI = VGA_CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VGA_CNT_W-1:0] V_BLNK_LO = VGA_CNT_W'(V_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] V_BLNK_HI = VGA_CNT_W'(V_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] V_SYNC_LO = VGA_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [VGA_CNT_W-1:0] V_SYNC_HI = VGA_CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [VGA_CNT_W-1:0] h_next_c;
  logic [VGA_CNT_W-1:0] v_next_c;
  logic                 h_wrap_c;
  logic                 v_wrap_c;

  vga_flags_t flags_q;
  vga_flags_t flags_d;

  // Pixel counter; its wrap advances the line counter
  vga_axis_counter #(
    .CNT_W (VGA_CNT_W),
    .TOTAL (H_TOTAL)
  ) u_h_cnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .en_i         (en),
    .count_o      (hcount),
    .count_next_c (h_next_c),
    .wrap_c       (h_wrap_c)
  );

  // Line counter; its wrap (only possible on a pixel wrap) marks frame end
  vga_axis_counter #(
    .CNT_W (VGA_CNT_W),
    .TOTAL (V_TOTAL)
  ) u_v_cnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .en_i         (h_wrap_c),
    .count_o      (vcount),
    .count_next_c (v_next_c),
    .wrap_c       (v_wrap_c)
  );

  // Decode from the next counter values so flags line up with hcount/vcount
  always_comb begin
    flags_d       = '0;
    flags_d.hblnk = in_window(h_next_c, H_BLNK_LO, H_BLNK_HI);
    flags_d.hsync = in_window(h_next_c, H_SYNC_LO, H_SYNC_HI);
    flags_d.vblnk = in_window(v_next_c, V_BLNK_LO, V_BLNK_HI);
    flags_d.vsync = in_window(v_next_c, V_SYNC_LO, V_SYNC_HI);
  end

  // Flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign hsync = flags_q.hsync;
  assign vsync = flags_q.vsync;
  assign hblnk = flags_q.hblnk;
  assign vblnk = flags_q.vblnk;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic                       tick_q;
  logic [VGA_FRAME_CNT_W-1:0] fcount_q;
  logic [VGA_FRAME_CNT_W-1:0] fcount_d;

  // Completed-frame count advances on every wrap from the last position
  always_comb begin
    fcount_d = fcount_q;
    if (v_wrap_c) begin
      fcount_d = fcount_q + VGA_FRAME_CNT_W'(1);
    end
  end

  // Tick and counter registers; a reset never produces a tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q   <= 1'b0;
      fcount_q <= '0;
    end else begin
      tick_q   <= v_wrap_c;
      fcount_q <= fcount_d;
    end
  end

  assign frame_tick  = tick_q;
  assign frame_count = fcount_q;
`else
  logic unused_v_wrap;

  assign unused_v_wrap = v_wrap_c;
  assign frame_tick    = 1'b0;
  assign frame_count   = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-timing instance for line-level checks and a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_timing;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // Small raster: 16 pixels x 11 lines = 176 cycles per frame
  localparam int SHA = 8, SHFP = 2, SHSY = 3, SHBP = 3;
  localparam int SVA = 6, SVFP = 1, SVSY = 2, SVBP = 2;
  localparam int SHT = SHA + SHFP + SHSY + SHBP;
  localparam int SVT = SVA + SVFP + SVSY + SVBP;
  localparam int SFR = SHT * SVT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        tick;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int steps;
    int h;
    int v;
    bit hs;
    bit hb;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_f_n, en_f, rst_s_n, en_s;
  logic [10:0] hc_f, vc_f, hc_s, vc_s;
  logic hs_f, vs_f, hb_f, vb_f, tk_f;
  logic hs_s, vs_s, hb_s, vb_s, tk_s;
  logic [15:0] fc_f, fc_s;

  int total = 0;
  int bad = 0;
  int n_f = 0, n_s = 0;
  bit last_f = 1'b0, last_s = 1'b0;

  vga_timing u_full (
    .clk (clk), .reset_n (rst_f_n), .en (en_f),
    .hcount (hc_f), .vcount (vc_f), .hsync (hs_f), .vsync (vs_f),
    .hblnk (hb_f), .vblnk (vb_f), .frame_tick (tk_f), .frame_count (fc_f)
  );

  vga_timing #(
    .H_ACTIVE (SHA), .H_FP (SHFP), .H_SYNC (SHSY), .H_BP (SHBP),
    .V_ACTIVE (SVA), .V_FP (SVFP), .V_SYNC (SVSY), .V_BP (SVBP)
  ) u_small (
    .clk (clk), .reset_n (rst_s_n), .en (en_s),
    .hcount (hc_s), .vcount (vc_s), .hsync (hs_s), .vsync (vs_s),
    .hblnk (hb_s), .vblnk (vb_s), .frame_tick (tk_s), .frame_count (fc_s)
  );

  function automatic obs_t obs_full();
    obs_t o;
    o = '{h: hc_f, v: vc_f, hs: hs_f, vs: vs_f, hb: hb_f, vb: vb_f, tick: tk_f, fc: fc_f};
    return o;
  endfunction

  function automatic obs_t obs_small();
    obs_t o;
    o = '{h: hc_s, v: vc_s, hs: hs_s, vs: vs_s, hb: hb_s, vb: vb_s, tick: tk_s, fc: fc_s};
    return o;
  endfunction

  // Reference: outputs as a function of enabled edges since reset
  function automatic obs_t model(input int n, input bit le,
                                 input int ha, input int hfp, input int hsy, input int hbp,
                                 input int va, input int vfp, input int vsy, input int vbp);
    obs_t m;
    int ht, vt, h, v;
    m  = '0;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    h  = n % ht;
    v  = (n / ht) % vt;
    m.h  = 11'(h);
    m.v  = 11'(v);
    m.hb = (h >= ha);
    m.hs = (h >= ha + hfp) && (h < ha + hfp + hsy);
    m.vb = (v >= va);
    m.vs = (v >= va + vfp) && (v < va + vfp + vsy);
    m.tick = FC_EN && le && (n > 0) && (n % (ht * vt) == 0);
    m.fc   = FC_EN ? 16'(n / (ht * vt)) : 16'd0;
    return m;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b tick=%0b fc=%0d",
                     o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.tick, o.fc);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_f(input logic e);
    en_f = e;
    @(posedge clk);
    #1;
    if (e) n_f++;
    last_f = e;
    check("full_cycle", obs_full(), model(n_f, last_f, 1024, 24, 136, 160, 768, 3, 6, 29));
  endtask

  task automatic step_s(input logic e);
    en_s = e;
    @(posedge clk);
    #1;
    if (e) n_s++;
    last_s = e;
    check("small_cycle", obs_small(), model(n_s, last_s, SHA, SHFP, SHSY, SHBP, SVA, SVFP, SVSY, SVBP));
  endtask

  initial begin
    vec_t tbl[10];
    obs_t exp;
    int hs_cnt, vs_cnt, budget;
    int vb_h, vb_v;
    bit vb_seen;

    // Line boundaries of the default 1024x768 raster
    tbl[0] = '{1,    1,    0, 0, 0};
    tbl[1] = '{1023, 1023, 0, 0, 0};
    tbl[2] = '{1024, 1024, 0, 0, 1};
    tbl[3] = '{1047, 1047, 0, 0, 1};
    tbl[4] = '{1048, 1048, 0, 1, 1};
    tbl[5] = '{1183, 1183, 0, 1, 1};
    tbl[6] = '{1184, 1184, 0, 0, 1};
    tbl[7] = '{1343, 1343, 0, 0, 1};
    tbl[8] = '{1344, 0,    1, 0, 0};
    tbl[9] = '{1345, 1,    1, 0, 0};

    rst_f_n = 1'b0; en_f = 1'b1;
    rst_s_n = 1'b0; en_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_full", obs_full(), '0);
    check("reset_small", obs_small(), '0);

    // Default raster: one line and a bit, table-driven boundaries
    rst_f_n = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      while (n_f < tbl[i].steps) begin
        step_f(1'b1);
        if (hs_f && n_f <= 1344) hs_cnt++;
      end
      exp = '0;
      exp.h  = 11'(tbl[i].h);
      exp.v  = 11'(tbl[i].v);
      exp.hs = tbl[i].hs;
      exp.hb = tbl[i].hb;
      check($sformatf("line_vec%0d", i), obs_full(), exp);
    end
    check_int("hsync_width", hs_cnt, 136);

    // Freeze at hcount=500 of line 1 for 100 cycles
    while (n_f < 1844) step_f(1'b1);
    check_int("hold_start_h", int'(hc_f), 500);
    repeat (100) step_f(1'b0);
    check_int("held_h", int'(hc_f), 500);
    check_int("held_v", int'(vc_f), 1);
    step_f(1'b1);
    check_int("resume_h", int'(hc_f), 501);
    rst_f_n = 1'b0;

    // Small raster: one full frame with en held high
    rst_s_n = 1'b1;
    vs_cnt = 0; vb_seen = 1'b0; vb_h = -1; vb_v = -1;
    while (n_s < SFR) begin
      step_s(1'b1);
      if (vs_s && n_s < SFR) vs_cnt++;
      if (vb_s && !vb_seen) begin
        vb_seen = 1'b1; vb_h = int'(hc_s); vb_v = int'(vc_s);
      end
    end
    check_int("vsync_cycles", vs_cnt, SVSY * SHT);
    check_int("vblnk_first_h", vb_h, 0);
    check_int("vblnk_first_v", vb_v, SVA);
    exp = '0;
    exp.tick = FC_EN;
    exp.fc   = FC_EN ? 16'd1 : 16'd0;
    check("frame_wrap", obs_small(), exp);
    step_s(1'b1);
    check_int("tick_one_cycle", int'(tk_s), 0);

    // Random enable pattern across two more frames
    budget = 0;
    while (n_s < 3 * SFR && budget < 5000) begin
      step_s(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      budget++;
    end
    if (budget >= 5000) check_int("random_budget", budget, 0);
    check_int("three_frames_fc", int'(fc_s), FC_EN ? 3 : 0);
    check_int("three_frames_tick", int'(tk_s), FC_EN ? 1 : 0);

    // Asynchronous reset mid-frame at (7,5)
    while (n_s < 3 * SFR + 5 * SHT + 7) step_s(1'b1);
    check_int("pre_rst_h", int'(hc_s), 7);
    check_int("pre_rst_v", int'(vc_s), 5);
    rst_s_n = 1'b0;
    #1;
    check("async_rst", obs_small(), '0);
    @(posedge clk);
    #1;
    check("rst_held", obs_small(), '0);
    rst_s_n = 1'b1;
    n_s = 0; last_s = 1'b0;
    step_s(1'b1);
    check_int("post_rst_h", int'(hc_s), 1);
    check_int("post_rst_tick", int'(tk_s), 0);
    repeat (20) step_s(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
